mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 5, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter WAIT, default 1, extra memory access cycles (legal range 0..7).
REQ-004 The port list SHALL be as follows: clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU controller access request, held until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
REQ-008 cpu_addr  in  AW  CPU address; stable while cpu_req.
REQ-009 cpu_wdata  in  DW  CPU write data.
REQ-010 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-011 cpu_rdata  out  DW  registered read data, valid with cpu_ack and held until next CPU read.
REQ-012 ld_req / ld_we / ld_addr / ld_wdata  in  1/1/AW/DW  program-loader port, same rules as CPU port.
REQ-013 ld_ack / ld_rdata  out  1/DW  loader completion pulse and registered read data.
REQ-014 halt  in  1  CPU halted; changes arbitration priority.
REQ-015 mem_rd / mem_wr  out  1/1  memory strobes.
REQ-016 mem_addr / mem_wdata  out  AW/DW  muxed memory address and write data.
REQ-017 mem_rdata  in  DW  memory read data.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, DONE; all outputs driven from registers or from state decode only (no req-to-output comb path).
REQ-020 IDLE: if any request is high at the clock edge, latch the grant (owner bit), we, addr, wdata; clear cnt; go to ACCESS; else stay.
REQ-021 Arbitration in IDLE: one request -> grant it; both requests with halt=1 -> loader; both with halt=0 -> requester not granted last (round-robin on last_owner).
REQ-022 ACCESS: mem_addr/mem_wdata = latched values; mem_rd = !we, mem_wr = we, asserted every ACCESS cycle; cnt increments each cycle.
REQ-023 ACCESS exits to DONE when cnt == WAIT; on that edge, for a read, mem_rdata is captured into the owner's rdata register only.
REQ-024 DONE: assert the owner's ack for exactly one cycle; update last_owner; return to IDLE unconditionally.
REQ-025 Latency: request sampled at edge N -> ACCESS for WAIT+1 cycles -> ack high in the cycle after edge N+WAIT+1; WAIT=1 gives ack 3 cycles after sampling.
REQ-026 A req still high in the IDLE cycle after DONE SHALL be treated as a new access; a requester drops req on the edge after seeing ack.
REQ-027 The non-owner's req, addr and data SHALL be ignored until IDLE; its ack SHALL stay 0.
REQ-028 Changes to halt during ACCESS/DONE SHALL not affect the current access.
REQ-029 Outside ACCESS: mem_rd = mem_wr = 0; mem_addr/mem_wdata hold last latched values.
REQ-030 cnt width SHALL be 3 bits; no wrap past WAIT.

Reset
REQ-031 rst low SHALL immediately force state IDLE, cnt 0, mem_rd/mem_wr/cpu_ack/ld_ack/busy 0, mem_addr/mem_wdata/cpu_rdata/ld_rdata 0, last_owner = loader (CPU wins first tie).
REQ-032 Reset asserted mid-ACCESS SHALL abort the access: no ack and no rdata update after release; requests still high after release are re-arbitrated from IDLE.

Verification
REQ-033 CPU read only, addr 5'h03, mem_rdata 8'hA5, WAIT=1: mem_rd high 2 cycles, cpu_ack 1 cycle, cpu_rdata 8'hA5, ld_ack 0.
REQ-034 Loader write addr 5'h1F data 8'h3C: mem_wr high 2 cycles with mem_addr 5'h1F, mem_wdata 8'h3C; ld_ack pulses once; cpu_rdata unchanged.
REQ-035 Both requests held high, halt=0, from reset: grants alternate CPU, loader, CPU, loader; each ack 3 cycles after its IDLE sample.
REQ-036 Both requests held high, halt=1: loader granted every time; cpu_ack never asserts until halt=0.
REQ-037 rst driven low in the second ACCESS cycle of a CPU read: strobes drop asynchronously; no cpu_ack; cpu_rdata 0; after release the held cpu_req completes normally.
REQ-038 WAIT=0 build: single ACCESS cycle; ack 2 cycles after sampling.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU controller and a program loader share one memory.
// Loader wins ties while the CPU is halted; otherwise ties alternate between the ports.
module mem_arbiter #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8,
  parameter int unsigned WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  input  logic          halt,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic          owner;
  logic          we;
  logic          last_owner;
  logic [CW-1:0] cnt;

  logic          grant_ld_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

  // Arbitration and request mux; only consumed on the IDLE grant edge.
  always_comb begin
    grant_ld_c = ld_req;
    if (cpu_req && ld_req) grant_ld_c = halt || (last_owner == OWN_CPU);
    sel_we_c    = grant_ld_c ? ld_we    : cpu_we;
    sel_addr_c  = grant_ld_c ? ld_addr  : cpu_addr;
    sel_wdata_c = grant_ld_c ? ld_wdata : cpu_wdata;
  end

  // Access sequencer; every output is a register so no request reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      we         <= 1'b0;
      last_owner <= OWN_LD;
      cnt        <= '0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ld_req) begin
            state     <= ACCESS;
            owner     <= grant_ld_c;
            we        <= sel_we_c;
            mem_addr  <= sel_addr_c;
            mem_wdata <= sel_wdata_c;
            mem_rd    <= !sel_we_c;
            mem_wr    <= sel_we_c;
            cnt       <= '0;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            cpu_ack <= (owner == OWN_CPU);
            ld_ack  <= (owner == OWN_LD);
            if (!we) begin
              if (owner == OWN_LD) ld_rdata  <= mem_rdata;
              else                 cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          cpu_ack    <= 1'b0;
          ld_ack     <= 1'b0;
          last_owner <= owner;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level timeline model and a reference memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned WAIT  = 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          halt = 1'b0;

  logic          cpu_ack, ld_ack, mem_rd, mem_wr, busy;
  logic [DW-1:0] cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          cpu_ack0, ld_ack0, mem_rd0, mem_wr0, busy0;
  logic [DW-1:0] cpu_rdata0, ld_rdata0, mem_wdata0;
  logic [AW-1:0] mem_addr0;

  logic          use_fixed = 1'b1;
  logic [DW-1:0] fixed_rdata = '0;
  logic          fill_req = 1'b0;
  logic [DW-1:0] fill_vals [DEPTH];
  logic [DW-1:0] mem_array [DEPTH];
  logic [DW-1:0] ref_mem   [DEPTH];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Memory behind the arbiter: writes land on the strobe edge, reads are combinational.
  always @(posedge clk) begin
    if (fill_req) mem_array <= fill_vals;
    else if (mem_wr) mem_array[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = use_fixed ? fixed_rdata : mem_array[mem_addr];

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .halt(halt), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack0), .ld_rdata(ld_rdata0),
    .halt(halt), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(fixed_rdata), .busy(busy0)
  );

  task automatic do_reset();
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = '0;  ld_wdata = '0;
    halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, mem_rd, mem_wr, cpu_ack, ld_ack} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_rd, mem_wr, cpu_ack, ld_ack});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, cpu_rdata, ld_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, ld_rdata});
    end
    rst = 1'b1;
  endtask

  task automatic test_cpu_read();
    int rd_cycles = 0, cack = 0, lack = 0, ack_at = 0;
    fixed_rdata = 8'hA5;
    cpu_we = 1'b0; cpu_addr = 5'h03; cpu_wdata = DW'($urandom); cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_rd && !mem_wr && mem_addr == 5'h03) rd_cycles++;
      if (ld_ack) lack++;
      if (cpu_ack) begin cack++; ack_at = c; cpu_req = 1'b0; end
    end
    n_cmp++;
    if (rd_cycles !== WAIT + 1) begin n_fail++; $display("FAIL cpu_read_rd_cycles: got %0d want %0d", rd_cycles, WAIT + 1); end
    n_cmp++;
    if (cack !== 1) begin n_fail++; $display("FAIL cpu_read_ack_count: got %0d want 1", cack); end
    n_cmp++;
    if (ack_at !== WAIT + 2) begin n_fail++; $display("FAIL cpu_read_latency: got %0d want %0d", ack_at, WAIT + 2); end
    n_cmp++;
    if (lack !== 0) begin n_fail++; $display("FAIL cpu_read_ld_ack: got %0d want 0", lack); end
    n_cmp++;
    if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL cpu_read_rdata: got %h want a5", cpu_rdata); end
  endtask

  task automatic test_ld_write();
    int wr_cycles = 0, rd_cycles = 0, lack = 0, ack_at = 0;
    fixed_rdata = 8'h00;
    ld_we = 1'b1; ld_addr = 5'h1F; ld_wdata = 8'h3C; ld_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_wr && mem_addr == 5'h1F && mem_wdata == 8'h3C) wr_cycles++;
      if (mem_rd) rd_cycles++;
      if (ld_ack) begin lack++; ack_at = c; ld_req = 1'b0; end
    end
    n_cmp++;
    if (wr_cycles !== WAIT + 1) begin n_fail++; $display("FAIL ld_write_wr_cycles: got %0d want %0d", wr_cycles, WAIT + 1); end
    n_cmp++;
    if (rd_cycles !== 0) begin n_fail++; $display("FAIL ld_write_rd_cycles: got %0d want 0", rd_cycles); end
    n_cmp++;
    if (lack !== 1 || ack_at !== WAIT + 2) begin
      n_fail++; $display("FAIL ld_write_ack: got count %0d at %0d want 1 at %0d", lack, ack_at, WAIT + 2);
    end
    n_cmp++;
    if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL ld_write_cpu_rdata: got %h want a5", cpu_rdata); end
  endtask

  task automatic test_round_robin();
    int owners[4];
    int cyc[4];
    int n = 0, both = 0;
    do_reset();
    cpu_we = 1'b0; cpu_addr = 5'h04; ld_we = 1'b0; ld_addr = 5'h08;
    cpu_req = 1'b1; ld_req = 1'b1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_ack && ld_ack) both++;
      if (cpu_ack || ld_ack) begin
        owners[n] = ld_ack ? 1 : 0; cyc[n] = c; n++;
        if (n == 4) begin cpu_req = 1'b0; ld_req = 1'b0; end
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    n_cmp++;
    if (n !== 4 || both !== 0) begin n_fail++; $display("FAIL rr_ack_count: got %0d (both %0d) want 4 (both 0)", n, both); end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (owners[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_owner[%0d]: got %0d want %0d", i, owners[i], i % 2); end
      n_cmp++;
      if (cyc[i] !== int'(WAIT + 2) + i * int'(WAIT + 3)) begin
        n_fail++; $display("FAIL rr_timing[%0d]: got %0d want %0d", i, cyc[i], int'(WAIT + 2) + i * int'(WAIT + 3));
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_halt();
    int n_ld = 0, cpu_early = 0, a4 = 0, cpu_first = 0;
    halt = 1'b1; cpu_req = 1'b1; ld_req = 1'b1;
    for (int c = 1; c <= 60 && cpu_first == 0; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        if (n_ld < 4) cpu_early++;
        else begin cpu_first = c; cpu_req = 1'b0; ld_req = 1'b0; end
      end
      if (ld_ack) begin
        n_ld++;
        if (n_ld == 4) begin halt = 1'b0; a4 = c; end
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    n_cmp++;
    if (cpu_early !== 0) begin n_fail++; $display("FAIL halt_cpu_ack: got %0d acks while halted want 0", cpu_early); end
    n_cmp++;
    if (n_ld !== 4) begin n_fail++; $display("FAIL halt_ld_grants: got %0d want 4", n_ld); end
    n_cmp++;
    if (cpu_first !== a4 + int'(WAIT + 3)) begin
      n_fail++; $display("FAIL halt_release_cpu: got ack at %0d want %0d", cpu_first, a4 + int'(WAIT + 3));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cack = 0, ack_at = 0;
    do_reset();
    fixed_rdata = 8'hA5;
    cpu_we = 1'b0; cpu_addr = 5'h03; cpu_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL abort_first_access: got mem_rd %b want 1", mem_rd); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd, mem_wr, busy} !== 3'b000) begin n_fail++; $display("FAIL abort_async: got %b want 000", {mem_rd, mem_wr, busy}); end
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== '0) begin
      n_fail++; $display("FAIL abort_no_ack: got ack %b rdata %h want 0 00", cpu_ack, cpu_rdata);
    end
    rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cpu_ack) begin cack++; ack_at = c; cpu_req = 1'b0; end
    end
    n_cmp++;
    if (cack !== 1 || ack_at !== WAIT + 2 || cpu_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL abort_retry: got %0d acks at %0d rdata %h want 1 at %0d rdata a5", cack, ack_at, cpu_rdata, WAIT + 2);
    end
  endtask

  task automatic test_wait0();
    int rd0 = 0, ack0 = 0, ack0_at = 0, busy0_cyc = 0, bad0 = 0;
    do_reset();
    fixed_rdata = 8'h5A;
    cpu_we = 1'b0; cpu_addr = 5'h03; cpu_wdata = 8'h77; cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_rd0) begin rd0++; if (mem_addr0 != 5'h03 || mem_wdata0 != 8'h77) bad0++; end
      if (busy0) busy0_cyc++;
      if (ld_ack0 || mem_wr0) bad0++;
      if (cpu_ack0) begin ack0++; ack0_at = c; end
      if (cpu_ack) cpu_req = 1'b0;
    end
    n_cmp++;
    if (rd0 !== 1) begin n_fail++; $display("FAIL wait0_rd_cycles: got %0d want 1", rd0); end
    n_cmp++;
    if (ack0 !== 1 || ack0_at !== 2) begin n_fail++; $display("FAIL wait0_latency: got %0d acks at %0d want 1 at 2", ack0, ack0_at); end
    n_cmp++;
    if (busy0_cyc !== 2 || bad0 !== 0) begin n_fail++; $display("FAIL wait0_busy: got busy %0d bad %0d want 2 0", busy0_cyc, bad0); end
    n_cmp++;
    if (cpu_rdata0 !== 8'h5A || ld_rdata0 !== '0) begin
      n_fail++; $display("FAIL wait0_rdata: got cpu %h ld %h want 5a 00", cpu_rdata0, ld_rdata0);
    end
  endtask

  // Random traffic; the model tracks each transaction as a grant edge plus fixed-length timeline.
  task automatic test_random();
    bit act = 0, last_ld = 1, own_ld = 0, twe = 0;
    int g = 0, nxt = 0;
    logic [AW-1:0] taddr = '0, e_addr = '0;
    logic [DW-1:0] twd = '0, e_wd = '0, e_crd = '0, e_lrd = '0;
    logic [4:0] e_ctl;
    do_reset();
    use_fixed = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fill_vals[i] = DW'($urandom);
      ref_mem[i] = fill_vals[i];
    end
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    for (int k = 1; k <= 400 && n_fail < 30; k++) begin
      @(negedge clk);
      if (!act && k >= nxt && (cpu_req || ld_req)) begin
        if (cpu_req && ld_req) own_ld = halt ? 1'b1 : !last_ld;
        else own_ld = ld_req;
        twe   = own_ld ? ld_we : cpu_we;
        taddr = own_ld ? ld_addr : cpu_addr;
        twd   = own_ld ? ld_wdata : cpu_wdata;
        e_addr = taddr; e_wd = twd;
        if (twe) ref_mem[taddr] = twd;
        act = 1; g = k;
      end
      e_ctl = 5'b0;
      if (act && k <= g + int'(WAIT)) e_ctl = {1'b1, !twe, twe, 2'b00};
      else if (act && k == g + int'(WAIT) + 1) begin
        e_ctl = {1'b1, 2'b00, !own_ld, own_ld};
        if (!twe) begin
          if (own_ld) e_lrd = ref_mem[taddr];
          else e_crd = ref_mem[taddr];
        end
      end
      n_cmp++;
      if ({busy, mem_rd, mem_wr, cpu_ack, ld_ack} !== e_ctl) begin
        n_fail++; $display("FAIL rand_ctl k=%0d: got %b want %b", k, {busy, mem_rd, mem_wr, cpu_ack, ld_ack}, e_ctl);
      end
      n_cmp++;
      if (mem_addr !== e_addr || mem_wdata !== e_wd) begin
        n_fail++; $display("FAIL rand_bus k=%0d: got %h/%h want %h/%h", k, mem_addr, mem_wdata, e_addr, e_wd);
      end
      n_cmp++;
      if (cpu_rdata !== e_crd || ld_rdata !== e_lrd) begin
        n_fail++; $display("FAIL rand_rdata k=%0d: got %h/%h want %h/%h", k, cpu_rdata, ld_rdata, e_crd, e_lrd);
      end
      if (act && k == g + int'(WAIT) + 1) begin
        last_ld = own_ld; act = 0; nxt = k + 2;
      end
      if (cpu_ack) cpu_req = 1'b0;
      else if (!cpu_req) begin
        cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
        if ($urandom_range(0, 2) == 0) cpu_req = 1'b1;
      end
      if (ld_ack) ld_req = 1'b0;
      else if (!ld_req) begin
        ld_we = 1'($urandom); ld_addr = AW'($urandom); ld_wdata = DW'($urandom);
        if ($urandom_range(0, 2) == 0) ld_req = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) halt = ~halt;
    end
    cpu_req = 1'b0; ld_req = 1'b0; halt = 1'b0;
    use_fixed = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_round_robin();
    test_halt();
    test_reset_abort();
    test_wait0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
